shared_reg_arbiter: RTL

- Round-robin arbiter and sequencer that shares one WIDTH-bit storage register (a bank of the team's d-flip-flops) between N_REQ requesters.
- Grants exclusive write access to one requester at a time and bounds each grant to MAX_HOLD writes.
- Sits between the requesting blocks and the shared register.
- Exposes the register contents, the current owner and a per-write acknowledge.

---
 rtl/shared_reg_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit register between N_REQ requesters.
// Each grant allows at most MAX_HOLD consecutive writes and is followed by one idle cycle.
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           wr_ack,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] wr_ack_q, wr_ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] wdata_arr [N_REQ];
  logic [WIDTH-1:0] owner_wdata;
  logic             owner_req;
  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW:0]     cand;
  logic [IDW-1:0]   next_ptr;
  logic             last_write;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign owner_wdata = wdata_arr[owner_q];
  assign owner_req   = req[owner_q];
  assign next_ptr    = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign last_write  = (cnt_q == CW'(MAX_HOLD - 1));

  // Rotating priority search starting at ptr_q; the extra bit of cand lets the
  // wrap be done by subtraction so non-power-of-two N_REQ never overshoots.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    wr_ack_d = '0;
    q_d      = q_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (owner_req) begin
          q_d      = owner_wdata;
          wr_ack_d = N_REQ'(1) << owner_q;
          cnt_d    = cnt_q + 1'b1;
        end
        // Release on a dropped request or on the final permitted write.
        if (!owner_req || last_write) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      wr_ack_q <= '0;
      q_q      <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      wr_ack_q <= wr_ack_d;
      q_q      <= q_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign wr_ack = wr_ack_q;
  assign q      = q_q;
  assign owner  = owner_q;
  assign busy   = busy_q;

endmodule
